ps2_kbd_ctrl: RTL
=================

Name: ps2_kbd_ctrl

Overview:
- Parametrised PS/2 keyboard front end; next generation of the keyboard-to-display path on the board top level.
- Receives 11-bit PS/2 frames and checks start, stop and odd parity.
- Adds an inter-bit timeout, a raw scan-code FIFO with pop interface and overflow flag, a make/break/extended (E0) decoder and a new-press counter.
- Decoder outputs drive the seven-segment driver; the FIFO serves a future CPU/UART consumer.

Parameters:
- FIFO_DEPTH, 8, raw byte FIFO entries; power of 2, ≥2.
- COUNT_W, 8, width of key_cnt.
- TIMEOUT_CYC, 20000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ps2_clk  in  1  PS/2 clock pad, asynchronous
- ps2_data  in  1  PS/2 data pad, asynchronous
- rd_en  in  1  pop request, FIFO head
- ovf_clr  in  1  clears overflow
- rd_data  out  8  FIFO head byte, first-word-fall-through
- rd_valid  out  1  FIFO not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky: a valid byte was dropped
- key_code  out  8  last make code
- key_ext  out  1  last make was E0-prefixed
- key_down  out  1  key_code currently held; also the display enable
- key_cnt  out  COUNT_W  new-press count, wraps mod 2^COUNT_W
- err_cnt  out  8  frame error count (parity, start, stop, timeout), saturates at 255

Behaviour:
- **Reset (rst=0):** async clear of everything. All outputs 0, FIFO empty, FSM IDLE, bit counter 0, sync chain all 1s (idle bus).
- **Synchroniser:** ps2_clk and ps2_data each pass through 2 flops, plus 1 history flop on clk.
  - fall = hist & ~sync.
  - Data is sampled from the synchronised ps2_data on the fall cycle.
- **Receiver:**
  - On each fall: shift the bit into a 10-bit buffer (LSB first), bitcnt++.
  - On the fall with bitcnt==10 (11th bit), evaluate the frame. Valid requires start==0, stop==1, and XOR(data[7:0], parity)==1.
  - bitcnt returns to 0 after every 11th bit.
  - Valid frame: byte_stb pulses 1 cycle, with byte = data[7:0].
  - Invalid frame: err_cnt++, no strobe.
- **Timeout:**
  - An idle counter runs while bitcnt≠0 and clears on each fall.
  - Reaching TIMEOUT_CYC sets bitcnt=0 and err_cnt++.
  - Counter is held at 0 while bitcnt==0.
- **Latency:** the clk edge that first samples the stop-bit fall at the pad is edge 0.
  - rd_valid/rd_data and decoder outputs update on edge 3.
  - Latency is fixed; this exact figure is what benches check.
- **FIFO:** FWFT; rd_data is valid whenever rd_valid=1.
  - Push on byte_stb if not full.
  - Pop on rd_en & rd_valid; rd_en while empty is ignored.
  - Push and pop in the same cycle: both happen and level is unchanged, including when full (no overflow).
  - Push while full with no pop: byte dropped, overflow←1.
  - ovf_clr clears overflow; if a drop occurs the same cycle, set wins.
  - Pointers wrap at FIFO_DEPTH.
- **Decoder FSM:** states IDLE, EXT, BRK, EXT_BRK; advances only on byte_stb.
  - IDLE: byte E0→EXT; F0→BRK; else make(byte, ext=0).
  - EXT: F0→EXT_BRK; E0→EXT; else make(byte, ext=1), →IDLE.
  - BRK: if byte==key_code & key_ext==0 & key_down, then key_down←0; →IDLE.
  - EXT_BRK: same as BRK with ext=1; →IDLE.
  - Break of a different key: ignored, no output change.
  - make(c,e): key_cnt++ unless (key_down & c==key_code & e==key_ext), so typematic repeat does not count. Then key_code←c, key_ext←e, key_down←1.
- The decoder operates independently of the FIFO; a full FIFO does not stall decoding.
- Reset mid-frame or mid-sequence: partial frame and prefix state are lost; reception resumes at the next start bit.

Test Plan:
- **Make/break 'A':** send frames 1C, F0, 1C with correct parity.
  - After the first frame: key_code=1C, key_down=1, key_cnt=1.
  - After the last frame: key_down=0.
  - FIFO holds 1C, F0, 1C (level=3).
  - Popping 3 times yields that order, then rd_valid=0.
- **Typematic and extended:** send 1C×3, then E0 75, then E0 F0 75.
  - key_cnt=2 after E0 75, with key_code=75, key_ext=1.
  - After E0 F0 75: key_down=0; a following F0 1C leaves key_down=0 and no change.
- **Frame errors:** send a 1C frame with flipped parity, then one with stop=0.
  - err_cnt=2, no FIFO push, decoder unchanged.
  - A following valid 1B is decoded normally.
- **Timeout:** send 5 bits of a frame, idle TIMEOUT_CYC+2 cycles, then send a full 29 frame.
  - err_cnt=1, then key_code=29, level=1.
- **Overflow and boundary:** FIFO_DEPTH=4, push 5 bytes with no pops.
  - level=4, overflow=1, head = first byte.
  - Pop concurrent with a push at full: level stays 4, overflow unchanged.
  - ovf_clr clears overflow.
- **Async reset:** assert rst=0 mid-frame with FIFO level=2 and key_down=1.
  - All outputs are 0 immediately, without waiting for clk.
  - After release, a 1C frame gives key_cnt=1 and level=1.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard front end: pad synchroniser, 11-bit frame receiver with
// start/stop/odd-parity check and inter-bit timeout, FWFT raw scan-code
// FIFO with sticky overflow, and a make/break/E0 decoder with press count.
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_W     = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_down,
  output logic [COUNT_W-1:0]            key_cnt,
  output logic [7:0]                    err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } dec_state_t;

  // Synchroniser and edge history
  logic          r_clk_s1, r_clk_s2, r_clk_hist;
  logic          r_dat_s1, r_dat_s2;
  logic          w_fall;

  // Receiver
  logic [9:0]    r_shift;
  logic [3:0]    r_bitcnt;
  logic [TW-1:0] r_idle;
  logic          r_byte_stb;
  logic [7:0]    r_byte;
  logic [7:0]    r_err_cnt;
  logic          w_frame_ok;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          w_full, w_push, w_pop;

  // Decoder
  dec_state_t         r_state, w_state_nx;
  logic [7:0]         r_key_code, w_code_nx;
  logic               r_key_ext, w_ext_nx;
  logic               r_key_down, w_down_nx;
  logic [COUNT_W-1:0] r_key_cnt, w_cnt_nx;
  logic               w_do_make, w_make_ext;

  // Two-flop synchronisers plus one history flop; idle bus reads as 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_hist & ~r_clk_s2;

  // After ten shifts r_shift holds {parity, data[7:0], start}; the stop bit
  // is the live sample on the eleventh fall, so it is never shifted in.
  assign w_frame_ok = ~r_shift[0] & r_dat_s2 & (^r_shift[9:1]);

  // Frame assembly, validation, inter-bit timeout and error counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_idle     <= '0;
      r_byte_stb <= 1'b0;
      r_byte     <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_byte_stb <= 1'b0;
      if (w_fall) begin
        r_idle <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= '0;
          if (w_frame_ok) begin
            r_byte_stb <= 1'b1;
            r_byte     <= r_shift[8:1];
          end else if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end else begin
          r_shift  <= {r_dat_s2, r_shift[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (r_idle == TW'(TIMEOUT_CYC - 1)) begin
          r_idle   <= '0;
          r_bitcnt <= '0;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
          r_idle <= r_idle + TW'(1);
        end
      end else begin
        r_idle <= '0;
      end
    end
  end

  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_pop  = rd_en & rd_valid;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_push = r_byte_stb & (~w_full | w_pop);

  // FIFO storage; contents need no reset since rd_data is gated by rd_valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_byte;
  end

  // FIFO pointers, occupancy and sticky overflow (drop beats clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (r_byte_stb && w_full && !w_pop) r_overflow <= 1'b1;
      else if (ovf_clr)                   r_overflow <= 1'b0;
    end
  end

  // Decoder next-state and key register updates, advancing only on byte_stb
  always_comb begin
    w_state_nx = r_state;
    w_code_nx  = r_key_code;
    w_ext_nx   = r_key_ext;
    w_down_nx  = r_key_down;
    w_cnt_nx   = r_key_cnt;
    w_do_make  = 1'b0;
    w_make_ext = 1'b0;
    if (r_byte_stb) begin
      case (r_state)
        S_IDLE: begin
          if (r_byte == 8'hE0)      w_state_nx = S_EXT;
          else if (r_byte == 8'hF0) w_state_nx = S_BRK;
          else                      w_do_make  = 1'b1;
        end
        S_EXT: begin
          if (r_byte == 8'hF0)      w_state_nx = S_EXT_BRK;
          else if (r_byte == 8'hE0) w_state_nx = S_EXT;
          else begin
            w_do_make  = 1'b1;
            w_make_ext = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          if (r_key_down && r_byte == r_key_code &&
              r_key_ext == (r_state == S_EXT_BRK))
            w_down_nx = 1'b0;
          w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
      if (w_do_make) begin
        if (!(r_key_down && r_byte == r_key_code && w_make_ext == r_key_ext))
          w_cnt_nx = r_key_cnt + COUNT_W'(1);
        w_code_nx = r_byte;
        w_ext_nx  = w_make_ext;
        w_down_nx = 1'b1;
      end
    end
  end

  // Decoder state and key output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_key_code <= '0;
      r_key_ext  <= 1'b0;
      r_key_down <= 1'b0;
      r_key_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_key_code <= w_code_nx;
      r_key_ext  <= w_ext_nx;
      r_key_down <= w_down_nx;
      r_key_cnt  <= w_cnt_nx;
    end
  end

  assign rd_valid   = (r_level != '0);
  assign rd_data    = rd_valid ? r_mem[r_rptr] : '0;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_down   = r_key_down;
  assign key_cnt    = r_key_cnt;
  assign err_cnt    = r_err_cnt;

endmodule
